// File: rtl/byte_assembler_pkg.sv
// Shared defaults and types for the byte assembler and its FIFO.
package byte_assembler_pkg;

    localparam int unsigned WORD_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RCT_LIMIT_DEF  = 32;

    // Word type at the default width.
    typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with circular pointers and an occupancy count.
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop happens on the same edge. The head reads as zero while empty.
module sync_fifo
    import byte_assembler_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage write.
    // NOTE: the storage array has no reset; the empty flag masks stale contents,
    // so clearing it would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/byte_assembler.sv
// Serial-to-parallel assembler for a random bit stream.
// Accepted bits fill a word LSB first; each completed word goes into a FIFO.
// Optional feature, compiled in by BYTE_ASSEMBLER_HEALTH_EN: a repetition-count
// health test that trips after RCT_LIMIT equal bits in a row. Once it trips,
// new words are discarded and words already in the FIFO can still be read.
module byte_assembler
    import byte_assembler_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned RCT_LIMIT  = RCT_LIMIT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic                          i_bit,
    output logic                          o_valid,
    output logic [WORD_W-1:0]             o_data,
    input  logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_health_fail
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              overflow_q, overflow_d;
    logic              word_done, push_req, pop_req;
    logic              fifo_full, fifo_empty;
    logic              health_block;

    assign word_done = i_valid && (bit_cnt_q == CNT_W'(WORD_W - 1));
    assign pop_req   = o_valid && o_ready;
    assign push_req  = word_done && !health_block;
    assign o_valid   = !fifo_empty;

    // Place each accepted bit at its position and advance the bit counter.
    // NOTE: every output gets a default first, so this block never infers a latch.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        overflow_d = overflow_q;
        if (i_valid) begin
            // NOTE: blocking assignments are right here because shift_d is
            // read back below as the completed word in the same evaluation.
            shift_d[bit_cnt_q] = i_bit;
            bit_cnt_d          = word_done ? '0 : bit_cnt_q + 1'b1;
        end
        if (push_req && fifo_full && !pop_req) begin
            overflow_d = 1'b1;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  (shift_d),
        .pop_i   (o_ready),
        .data_o  (o_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (o_level)
    );

`ifdef BYTE_ASSEMBLER_HEALTH_EN
    localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_bit_q;
    logic             health_q, health_d;

    // Count equal consecutive bits across word boundaries; saturate at the limit.
    always_comb begin
        run_d    = run_q;
        health_d = health_q;
        if (i_valid) begin
            if (run_q == '0 || i_bit != last_bit_q) begin
                run_d = RUN_W'(1);
            end else if (run_q != RUN_W'(RCT_LIMIT)) begin
                run_d = run_q + 1'b1;
            end
            if (run_d == RUN_W'(RCT_LIMIT)) begin
                health_d = 1'b1;
            end
        end
    end

    // Health test state registers; the fail flag is held until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= '0;
            last_bit_q <= 1'b0;
            health_q   <= 1'b0;
        end else begin
            run_q    <= run_d;
            health_q <= health_d;
            if (i_valid) last_bit_q <= i_bit;
        end
    end

    // The word that completes on the tripping edge is still pushed.
    assign health_block  = health_q;
    assign o_health_fail = health_q;
`else
    assign health_block  = 1'b0;
    assign o_health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_byte_assembler.sv
// Directed bench for byte_assembler. Expected words go into a scoreboard queue
// when their bits are driven and are checked when the DUT pops them.
module tb_byte_assembler;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
`ifdef BYTE_ASSEMBLER_HEALTH_EN
    localparam logic HEALTH_EN = 1'b1;
`else
    localparam logic HEALTH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              i_bit;
    logic              o_valid;
    logic [WORD_W-1:0] o_data;
    logic              o_ready;
    logic [2:0]        o_level;
    logic              o_overflow;
    logic              o_health_fail;

    int checks   = 0;
    int failures = 0;
    logic [WORD_W-1:0] sb[$];

    always #5 clk = ~clk;

    byte_assembler #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (DEPTH),
        .RCT_LIMIT  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_bit         (i_bit),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_ready       (o_ready),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .o_health_fail (o_health_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the head if it is being popped, then advance.
    task automatic step(input logic v, input logic b, input logic r);
        i_valid = v;
        i_bit   = b;
        o_ready = r;
        if (o_valid && r) begin
            if (sb.size() == 0) check("unexpected_valid", o_valid, 0);
            else                check("pop_data", o_data, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_bit   = 1'b0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // mode: 0 ready low, 1 ready high, 2 random ready (high on last bit), 3 ready only on last bit
    task automatic feed_word(input logic [WORD_W-1:0] w, input bit keep, input int mode);
        if (keep) sb.push_back(w);
        for (int k = 0; k < WORD_W; k++) begin
            logic r;
            case (mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = (k == WORD_W - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                default: r = (k == WORD_W - 1);
            endcase
            step(1'b1, w[k], r);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16 && o_valid; i++) step(1'b0, 1'b0, 1'b1);
        check({tag, "_drained_valid"}, o_valid, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WORD_W-1:0] pat;
        pat = 8'h8D;

        // Reset state
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_health", o_health_fail, 0);
        check("rst_data", o_data, 0);

        // Bits 1,0,1,1,0,0,0,1 on consecutive cycles
        sb.push_back(8'h8D);
        for (int k = 0; k < WORD_W; k++) begin
            step(1'b1, pat[k], 1'b0);
            if (k == WORD_W - 2) check("seq_early_valid", o_valid, 0);
        end
        check("seq_valid", o_valid, 1);
        check("seq_data", o_data, 8'h8D);
        check("seq_level", o_level, 1);
        drain("seq");

        // Same bits with i_valid gaps carrying the opposite bit
        sb.push_back(8'h8D);
        for (int k = 0; k < WORD_W; k++) begin
            step(1'b1, pat[k], 1'b0);
            if (k < WORD_W - 1) begin
                step(1'b0, ~pat[k], 1'b0);
                check("gap_early_valid", o_valid, 0);
            end
        end
        check("gap_data", o_data, 8'h8D);
        check("gap_level", o_level, 1);
        drain("gap");

        // Ready on an empty FIFO has no effect
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check("empty_pop_level", o_level, 0);
        check("empty_pop_valid", o_valid, 0);

        // Backpressure: five words into a depth-4 FIFO
        do_reset();
        feed_word(8'h11, 1'b1, 0);
        feed_word(8'h22, 1'b1, 0);
        feed_word(8'h33, 1'b1, 0);
        feed_word(8'h44, 1'b1, 0);
        check("full_no_ovf", o_overflow, 0);
        feed_word(8'h55, 1'b0, 0);
        check("ovf_level", o_level, 4);
        check("ovf_flag", o_overflow, 1);
        check("ovf_head_stable", o_data, 8'h11);
        drain("ovf");
        check("ovf_sticky", o_overflow, 1);

        // Full FIFO with a pop on the edge of the fifth push
        do_reset();
        feed_word(8'hA1, 1'b1, 0);
        feed_word(8'hB2, 1'b1, 0);
        feed_word(8'hC3, 1'b1, 0);
        feed_word(8'hD4, 1'b1, 0);
        feed_word(8'hE5, 1'b1, 3);
        check("fullpp_level", o_level, 4);
        check("fullpp_ovf", o_overflow, 0);
        check("fullpp_head", o_data, 8'hB2);
        drain("fullpp");

        // Push and pop together with exactly one word stored
        do_reset();
        feed_word(8'h3C, 1'b1, 0);
        feed_word(8'hC6, 1'b1, 3);
        check("onepp_level", o_level, 1);
        check("onepp_head", o_data, 8'hC6);
        drain("onepp");

        // Reset mid-word discards the partial bits; i_valid ignored during reset
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_bit   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_level0", o_level, 0);
        feed_word(8'h5A, 1'b1, 0);
        check("midrst_data", o_data, 8'h5A);
        check("midrst_level", o_level, 1);
        drain("midrst");

        // Random words with random backpressure; ready is high on each word's last bit
        do_reset();
        for (int i = 0; i < 6; i++) feed_word(WORD_W'($urandom), 1'b1, 2);
        drain("rand");
        check("rand_ovf", o_overflow, 0);

        // 32 consecutive ones, then one more word of ones with the FIFO full
        do_reset();
        feed_word(8'hFF, 1'b1, 0);
        feed_word(8'hFF, 1'b1, 0);
        feed_word(8'hFF, 1'b1, 0);
        for (int k = 0; k < WORD_W - 1; k++) step(1'b1, 1'b1, 1'b0);
        check("rct_31", o_health_fail, 0);
        sb.push_back(8'hFF);
        step(1'b1, 1'b1, 1'b0);
        check("rct_32", o_health_fail, 32'(HEALTH_EN));
        check("rct_level", o_level, 4);
        feed_word(8'hFF, 1'b0, 0);
        check("rct_after_level", o_level, 4);
        check("rct_after_ovf", o_overflow, 32'(!HEALTH_EN));
        check("rct_after_fail", o_health_fail, 32'(HEALTH_EN));
        drain("rct");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
- REQ-001: Parameter WORD_W, default 8, SHALL set the number of bits per output word.
- REQ-002: Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered words and SHALL be a power of two, at least 2.
- REQ-003: Parameter RCT_LIMIT, default 32, SHALL set the repetition-count threshold used by the health test.
- REQ-004: Clock and reset SHALL be `clk` and `rst`; reset is synchronous and active-high.
- REQ-005: Ports SHALL be, in this order:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - i_valid  in  1  input bit qualifier (from the unbiaser wrapper)
  - i_bit  in  1  input random bit
  - o_valid  out  1  FIFO head word available
  - o_data  out  WORD_W  FIFO head word
  - o_ready  in  1  consumer accepts the head word
  - o_level  out  $clog2(FIFO_DEPTH)+1  words currently stored
  - o_overflow  out  1  sticky: a word was dropped
  - o_health_fail  out  1  sticky: health test tripped

Function
- REQ-006: A bit SHALL be accepted on every rising clk edge where i_valid=1 and rst=0; i_bit is sampled at that edge.
- REQ-007: Bit ordering SHALL be LSB-first: the k-th accepted bit of a word (k=0..WORD_W-1) SHALL land in o_data[k].
- REQ-008: A bit counter 0..WORD_W-1 SHALL advance on each accepted bit and wrap to 0 after WORD_W-1.
- REQ-009: On the edge that accepts bit WORD_W-1, the completed word SHALL be pushed into the FIFO.
- REQ-010: A pushed word SHALL be visible at o_data with o_valid=1 from the next cycle when the FIFO was empty (latency: 1 cycle after the last bit edge).
- REQ-011: A pop SHALL occur on an edge with o_valid=1 and o_ready=1; o_data and o_valid SHALL stay stable while o_valid=1 and o_ready=0.
- REQ-012: The FIFO SHALL be first-in first-out, with circular read/write pointers wrapping modulo FIFO_DEPTH.
- REQ-013: On a push with the FIFO full and no pop on the same edge, the word SHALL be discarded, FIFO contents SHALL be unchanged, and o_overflow SHALL be set.
- REQ-014: A simultaneous push and pop SHALL always succeed, including when the FIFO is full or when it holds exactly one word; o_level SHALL be unchanged.
- REQ-015: A pop with o_valid=0 SHALL be ignored; o_ready SHALL have no effect when the FIFO is empty.
- REQ-016: o_level SHALL equal pushes minus pops since reset, in the range 0..FIFO_DEPTH, and SHALL update on the same edge as the push or pop.
- REQ-017: Bit assembly SHALL continue independently of o_ready; backpressure never stalls input acceptance.

Reset
- REQ-018: While rst=1 at an edge, the module SHALL clear the bit counter, the partial word, the FIFO pointers, o_level, o_overflow, o_health_fail and the repetition counter, and SHALL drive o_valid=0.
- REQ-019: During a reset edge, i_valid SHALL be ignored; a partial word in progress SHALL be lost.
- REQ-020: Reset values SHALL be: o_valid=0, o_level=0, o_overflow=0, o_health_fail=0; o_data SHALL be 0 after reset until the first push.

Configuration
- REQ-021: Macro BYTE_ASSEMBLER_HEALTH_EN SHALL compile in the repetition-count test.
- REQ-022: With the macro defined:
  - a run counter SHALL count consecutive equal accepted bits, spanning word boundaries;
  - when the run reaches RCT_LIMIT, o_health_fail SHALL be set on that edge and stay set until rst;
  - while o_health_fail=1, completed words SHALL be discarded without setting o_overflow;
  - words already in the FIFO remain poppable.
- REQ-023: Without the macro, o_health_fail SHALL be tied to 0, no run counter SHALL exist, and RCT_LIMIT SHALL be unused.

Structure
- REQ-024: A shared package byte_assembler_pkg SHALL hold the WORD_W and FIFO_DEPTH defaults, the RCT_LIMIT default, and a word typedef.
- REQ-025: The FIFO SHALL be a sub-module sync_fifo (push, pop, full, empty, level), instantiated once; the assembler and health logic live in byte_assembler.

Verification
- REQ-026: Feed bits 1,0,1,1,0,0,0,1 on consecutive cycles -> o_valid=1 one cycle after the 8th bit, o_data=8'h8D, o_level=1.
- REQ-027: Insert i_valid gaps between the same 8 bits -> same o_data=8'h8D; no output before the 8th accepted bit.
- REQ-028: Hold o_ready=0 and push 5 words -> o_level=4, o_overflow=1; draining yields the first 4 words in order.
- REQ-029: With the FIFO full and o_ready=1 on the edge of the 5th push -> no drop, o_overflow=0, o_level stays 4.
- REQ-030: Assert rst after 3 bits, then feed 8 bits -> the word contains only the post-reset bits; o_level=1.
- REQ-031: Macro defined, feed 32 consecutive 1s -> o_health_fail=1 on the 32nd bit edge; subsequent words are not pushed. Macro undefined -> 8'hFF words are pushed and o_health_fail=0.
